// File: rtl/nrisc_wishbone_arbiter.sv
// -----------------------------------------------------------------------------
// nrisc_wishbone_arbiter
//
// Two-master, one-slave Wishbone arbiter with round-robin tie breaking,
// bus locking and a slave-termination watchdog.
//
// Ports
//   WSHARB_CLKIN / WSHARB_RSTIN    clock, asynchronous active-high reset
//   WSHARB_Mx_CYC/STB/WE/LOCK      master x request signals (x = 0, 1)
//   WSHARB_Mx_ADDR/DATAOUT         master x address and write data
//   WSHARB_Mx_DATAIN               read data to master x (always the slave data)
//   WSHARB_Mx_ACK/ERR/RTY          termination to master x (granted master only)
//   WSHARB_S_CYC/STB/WE/LOCK       shared slave bus controls (0 when idle)
//   WSHARB_S_ADDR/DATAOUT          shared slave bus address and write data
//   WSHARB_S_DATAIN/ACK/ERR/RTY    slave response
//   WSHARB_GNT                     registered one-hot grant {M1, M0}
// -----------------------------------------------------------------------------
module nrisc_wishbone_arbiter #(
  parameter int TAM     = 16,
  parameter int TIMEOUT = 15
) (
  input  logic           WSHARB_CLKIN,
  input  logic           WSHARB_RSTIN,
  // master 0
  input  logic           WSHARB_M0_CYC,
  input  logic           WSHARB_M0_STB,
  input  logic           WSHARB_M0_WE,
  input  logic           WSHARB_M0_LOCK,
  input  logic [TAM-1:0] WSHARB_M0_ADDR,
  input  logic [TAM-1:0] WSHARB_M0_DATAOUT,
  output logic [TAM-1:0] WSHARB_M0_DATAIN,
  output logic           WSHARB_M0_ACK,
  output logic           WSHARB_M0_ERR,
  output logic           WSHARB_M0_RTY,
  // master 1
  input  logic           WSHARB_M1_CYC,
  input  logic           WSHARB_M1_STB,
  input  logic           WSHARB_M1_WE,
  input  logic           WSHARB_M1_LOCK,
  input  logic [TAM-1:0] WSHARB_M1_ADDR,
  input  logic [TAM-1:0] WSHARB_M1_DATAOUT,
  output logic [TAM-1:0] WSHARB_M1_DATAIN,
  output logic           WSHARB_M1_ACK,
  output logic           WSHARB_M1_ERR,
  output logic           WSHARB_M1_RTY,
  // shared slave bus
  output logic           WSHARB_S_CYC,
  output logic           WSHARB_S_STB,
  output logic           WSHARB_S_WE,
  output logic           WSHARB_S_LOCK,
  output logic [TAM-1:0] WSHARB_S_ADDR,
  output logic [TAM-1:0] WSHARB_S_DATAOUT,
  input  logic [TAM-1:0] WSHARB_S_DATAIN,
  input  logic           WSHARB_S_ACK,
  input  logic           WSHARB_S_ERR,
  input  logic           WSHARB_S_RTY,
  // grant
  output logic [1:0]     WSHARB_GNT
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  localparam logic [3:0] WDT_LIMIT = 4'(TIMEOUT);

  state_t     state, state_next;
  logic       last, last_next;      // 1 = M1 was granted most recently
  logic [3:0] wdt, wdt_next;
  logic [1:0] gnt_next;

  logic       g0, g1;
  logic       sel_stb;
  logic       slave_term;
  logic       wdt_hit;

  assign g0 = WSHARB_GNT[0];
  assign g1 = WSHARB_GNT[1];

  // ---------------------------------------------------------------------------
  // State registers. The grant is registered alongside the state so that
  // WSHARB_GNT comes straight from flops and reset clears it asynchronously.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge WSHARB_CLKIN or posedge WSHARB_RSTIN) begin
    if (WSHARB_RSTIN) begin
      state      <= IDLE;
      last       <= 1'b1;
      wdt        <= 4'd0;
      WSHARB_GNT <= 2'b00;
    end else begin
      state      <= state_next;
      last       <= last_next;
      wdt        <= wdt_next;
      WSHARB_GNT <= gnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. A tenure always returns to IDLE for one cycle, which is
  // where the round-robin decision is made.
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default first so no path through
  // the block leaves it unassigned (which would infer a latch).
  always_comb begin
    state_next = state;
    last_next  = last;
    case (state)
      IDLE: begin
        // M0 wins when it asks alone, or on a tie when M1 had the last turn.
        if (WSHARB_M0_CYC && (!WSHARB_M1_CYC || last)) begin
          state_next = GRANT0;
          last_next  = 1'b0;
        end else if (WSHARB_M1_CYC) begin
          state_next = GRANT1;
          last_next  = 1'b1;
        end
      end
      GRANT0: if (!WSHARB_M0_CYC && !WSHARB_M0_LOCK) state_next = IDLE;
      GRANT1: if (!WSHARB_M1_CYC && !WSHARB_M1_LOCK) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    gnt_next = {state_next == GRANT1, state_next == GRANT0};
  end

  // ---------------------------------------------------------------------------
  // Slave bus multiplexer: zero-latency pass-through of the granted master.
  // ---------------------------------------------------------------------------
  always_comb begin
    WSHARB_S_CYC     = 1'b0;
    WSHARB_S_STB     = 1'b0;
    WSHARB_S_WE      = 1'b0;
    WSHARB_S_LOCK    = 1'b0;
    WSHARB_S_ADDR    = '0;
    WSHARB_S_DATAOUT = '0;
    if (g0) begin
      WSHARB_S_CYC     = WSHARB_M0_CYC;
      WSHARB_S_STB     = WSHARB_M0_STB;
      WSHARB_S_WE      = WSHARB_M0_WE;
      WSHARB_S_LOCK    = WSHARB_M0_LOCK;
      WSHARB_S_ADDR    = WSHARB_M0_ADDR;
      WSHARB_S_DATAOUT = WSHARB_M0_DATAOUT;
    end else if (g1) begin
      WSHARB_S_CYC     = WSHARB_M1_CYC;
      WSHARB_S_STB     = WSHARB_M1_STB;
      WSHARB_S_WE      = WSHARB_M1_WE;
      WSHARB_S_LOCK    = WSHARB_M1_LOCK;
      WSHARB_S_ADDR    = WSHARB_M1_ADDR;
      WSHARB_S_DATAOUT = WSHARB_M1_DATAOUT;
    end
  end

  // ---------------------------------------------------------------------------
  // Watchdog: counts strobed cycles the slave leaves unterminated. Reaching the
  // limit injects a one-cycle error to the granted master and restarts the count.
  // ---------------------------------------------------------------------------
  assign sel_stb    = (g0 & WSHARB_M0_STB) | (g1 & WSHARB_M1_STB);
  assign slave_term = WSHARB_S_ACK | WSHARB_S_ERR | WSHARB_S_RTY;
  assign wdt_hit    = (g0 | g1) && (wdt == WDT_LIMIT);

  always_comb begin
    if (!sel_stb || slave_term || wdt_hit) wdt_next = 4'd0;
    else                                   wdt_next = wdt + 4'd1;
  end

  // ---------------------------------------------------------------------------
  // Responses: data goes to both masters, terminations only to the granted one.
  // Simultaneous ACK and ERR from the slave are passed through as they are.
  // ---------------------------------------------------------------------------
  assign WSHARB_M0_DATAIN = WSHARB_S_DATAIN;
  assign WSHARB_M1_DATAIN = WSHARB_S_DATAIN;

  assign WSHARB_M0_ACK = g0 & WSHARB_S_ACK;
  assign WSHARB_M0_ERR = g0 & (WSHARB_S_ERR | wdt_hit);
  assign WSHARB_M0_RTY = g0 & WSHARB_S_RTY;
  assign WSHARB_M1_ACK = g1 & WSHARB_S_ACK;
  assign WSHARB_M1_ERR = g1 & (WSHARB_S_ERR | wdt_hit);
  assign WSHARB_M1_RTY = g1 & WSHARB_S_RTY;

endmodule

// File: tb/tb_nrisc_wishbone_arbiter.sv
// -----------------------------------------------------------------------------
// tb_nrisc_wishbone_arbiter
//
// Directed bench for nrisc_wishbone_arbiter. Inputs change 1 ns after a rising
// edge; outputs are sampled 1 ns after the inputs change, away from any edge.
// -----------------------------------------------------------------------------
module tb_nrisc_wishbone_arbiter;

  localparam int TAM = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           m0_cyc, m0_stb, m0_we, m0_lock;
  logic [TAM-1:0] m0_addr, m0_dataout, m0_datain;
  logic           m0_ack, m0_err, m0_rty;
  logic           m1_cyc, m1_stb, m1_we, m1_lock;
  logic [TAM-1:0] m1_addr, m1_dataout, m1_datain;
  logic           m1_ack, m1_err, m1_rty;
  logic           s_cyc, s_stb, s_we, s_lock;
  logic [TAM-1:0] s_addr, s_dataout, s_datain;
  logic           s_ack, s_err, s_rty;
  logic [1:0]     gnt;

  int check_count = 0;
  int error_count = 0;

  always #5 clk = ~clk;

  nrisc_wishbone_arbiter #(.TAM(TAM), .TIMEOUT(15)) dut (
    .WSHARB_CLKIN      (clk),
    .WSHARB_RSTIN      (rst),
    .WSHARB_M0_CYC     (m0_cyc),
    .WSHARB_M0_STB     (m0_stb),
    .WSHARB_M0_WE      (m0_we),
    .WSHARB_M0_LOCK    (m0_lock),
    .WSHARB_M0_ADDR    (m0_addr),
    .WSHARB_M0_DATAOUT (m0_dataout),
    .WSHARB_M0_DATAIN  (m0_datain),
    .WSHARB_M0_ACK     (m0_ack),
    .WSHARB_M0_ERR     (m0_err),
    .WSHARB_M0_RTY     (m0_rty),
    .WSHARB_M1_CYC     (m1_cyc),
    .WSHARB_M1_STB     (m1_stb),
    .WSHARB_M1_WE      (m1_we),
    .WSHARB_M1_LOCK    (m1_lock),
    .WSHARB_M1_ADDR    (m1_addr),
    .WSHARB_M1_DATAOUT (m1_dataout),
    .WSHARB_M1_DATAIN  (m1_datain),
    .WSHARB_M1_ACK     (m1_ack),
    .WSHARB_M1_ERR     (m1_err),
    .WSHARB_M1_RTY     (m1_rty),
    .WSHARB_S_CYC      (s_cyc),
    .WSHARB_S_STB      (s_stb),
    .WSHARB_S_WE       (s_we),
    .WSHARB_S_LOCK     (s_lock),
    .WSHARB_S_ADDR     (s_addr),
    .WSHARB_S_DATAOUT  (s_dataout),
    .WSHARB_S_DATAIN   (s_datain),
    .WSHARB_S_ACK      (s_ack),
    .WSHARB_S_ERR      (s_err),
    .WSHARB_S_RTY      (s_rty),
    .WSHARB_GNT        (gnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    assert (obs === exp)
    else begin
      error_count++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "simulation time limit exceeded");
  end

  initial begin
    rst = 1'b1;
    {m0_cyc, m0_stb, m0_we, m0_lock} = '0;
    {m1_cyc, m1_stb, m1_we, m1_lock} = '0;
    m0_addr = '0; m0_dataout = '0;
    m1_addr = '0; m1_dataout = '0;
    s_datain = '0; {s_ack, s_err, s_rty} = '0;

    // Reset state, including a slave ACK that must not leak to any master.
    #2;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_s_cyc", 32'(s_cyc), 32'h0);
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_addr = 16'h00A5; s_ack = 1'b1;
    #1;
    check("rst_m0_ack", 32'(m0_ack), 32'h0);
    check("rst_s_addr", 32'(s_addr), 32'h0);
    step();
    check("rst_hold_gnt", 32'(gnt), 32'h0);

    // Release with both masters requesting: LAST=1 so M0 wins.
    rst = 1'b0; s_ack = 1'b0;
    m0_we = 1'b0;
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1;
    m1_addr = 16'h0F0F; m1_dataout = 16'hBEEF;
    step();
    check("tie_gnt_m0", 32'(gnt), 32'h1);
    check("m0_s_addr", 32'(s_addr), 32'h00A5);
    check("m0_s_we", 32'(s_we), 32'h0);
    check("m0_s_cyc", 32'(s_cyc), 32'h1);
    check("m0_wait_ack", 32'(m0_ack), 32'h0);

    // Slave responds after two wait cycles.
    step();
    check("m0_wait2_ack", 32'(m0_ack), 32'h0);
    step();
    s_ack = 1'b1; s_datain = 16'h1234;
    #1;
    check("m0_ack", 32'(m0_ack), 32'h1);
    check("m0_datain", 32'(m0_datain), 32'h1234);
    check("m1_ack_blocked", 32'(m1_ack), 32'h0);
    check("m1_datain_shared", 32'(m1_datain), 32'h1234);

    // M0 finishes: one IDLE cycle, then M1 is served.
    m0_cyc = 1'b0; m0_stb = 1'b0; s_ack = 1'b0;
    step();
    check("idle_gnt", 32'(gnt), 32'h0);
    check("idle_s_cyc", 32'(s_cyc), 32'h0);
    check("idle_s_addr", 32'(s_addr), 32'h0);
    step();
    check("m1_gnt", 32'(gnt), 32'h2);
    check("m1_s_addr", 32'(s_addr), 32'h0F0F);
    check("m1_s_we", 32'(s_we), 32'h1);
    check("m1_s_dataout", 32'(s_dataout), 32'hBEEF);

    // Silent slave: error pulse exactly in the 16th strobed cycle.
    for (int i = 1; i <= 17; i++) begin
      if (i > 1) step();
      check($sformatf("wdt_m1_err_c%0d", i), 32'(m1_err), 32'((i == 16) ? 1 : 0));
      if (i == 16) check("wdt_m0_err", 32'(m0_err), 32'h0);
    end

    // Slave ERR passes through to the granted master only.
    s_err = 1'b1;
    #1;
    check("s_err_m1", 32'(m1_err), 32'h1);
    check("s_err_m0", 32'(m0_err), 32'h0);
    s_err = 1'b0;

    // M1 releases.
    m1_cyc = 1'b0; m1_stb = 1'b0;
    step();
    check("m1_release_gnt", 32'(gnt), 32'h0);

    // Locked M0 tenure: tie with LAST=1 goes to M0, grant held through CYC=0.
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_lock = 1'b1;
    m1_cyc = 1'b1; m1_stb = 1'b1;
    step();
    check("lock_gnt", 32'(gnt), 32'h1);
    m0_cyc = 1'b0; m0_stb = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      check($sformatf("lock_hold_c%0d", i), 32'(gnt), 32'h1);
    end
    check("lock_s_cyc", 32'(s_cyc), 32'h0);
    check("lock_s_lock", 32'(s_lock), 32'h1);
    m0_lock = 1'b0;
    step();
    check("unlock_idle", 32'(gnt), 32'h0);
    step();
    check("unlock_m1_gnt", 32'(gnt), 32'h2);

    // Round-robin with LAST=0: M0 alone, then a tie goes to M1.
    m1_cyc = 1'b0; m1_stb = 1'b0;
    step();
    check("rr_idle1", 32'(gnt), 32'h0);
    m0_cyc = 1'b1; m0_stb = 1'b1;
    step();
    check("rr_m0_alone", 32'(gnt), 32'h1);
    m0_cyc = 1'b0; m0_stb = 1'b0;
    step();
    check("rr_idle2", 32'(gnt), 32'h0);
    m0_cyc = 1'b1; m0_stb = 1'b1;
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b0; m1_addr = 16'h0042;
    step();
    check("rr_tie_m1", 32'(gnt), 32'h2);

    // Asynchronous reset in the middle of M1's read.
    #3;
    rst = 1'b1; s_ack = 1'b1;
    #1;
    check("arst_gnt", 32'(gnt), 32'h0);
    check("arst_s_cyc", 32'(s_cyc), 32'h0);
    check("arst_s_stb", 32'(s_stb), 32'h0);
    check("arst_m1_ack", 32'(m1_ack), 32'h0);
    step();
    rst = 1'b0; s_ack = 1'b0;
    step();
    check("post_rst_tie_m0", 32'(gnt), 32'h1);
    s_ack = 1'b1;
    #1;
    check("post_rst_m0_ack", 32'(m0_ack), 32'h1);
    check("post_rst_m1_ack", 32'(m1_ack), 32'h0);
    check("post_rst_m1_rty", 32'(m1_rty), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/nrisc_wishbone_arbiter.md
NRISC_WISHBONE_ARBITER -- requirements
Module: nrisc_wishbone_arbiter

Interface
REQ-001 Parameter: TAM, 16, address/data width in bits.
REQ-002 Parameter: TIMEOUT, 15, max wait cycles for slave termination (1..15).
REQ-003 Port: WSHARB_CLKIN  in  1  single clock; all state updates on rising edge.
REQ-004 Port: WSHARB_RSTIN  in  1  reset, asynchronous, active-high.
REQ-005 Port: WSHARB_M0_CYC/_STB/_WE/_LOCK  in  1 each  master 0 cycle, strobe, write enable (1 = write), lock.
REQ-006 Port: WSHARB_M0_ADDR, WSHARB_M0_DATAOUT  in  TAM each  master 0 address and write data.
REQ-007 Port: WSHARB_M0_DATAIN  out  TAM  read data to master 0.
REQ-008 Port: WSHARB_M0_ACK/_ERR/_RTY  out  1 each  cycle termination to master 0.
REQ-009 Ports WSHARB_M1_* SHALL mirror REQ-005..REQ-008 for master 1.
REQ-010 Port: WSHARB_S_CYC/_STB/_WE/_LOCK  out  1 each  to shared slave bus.
REQ-011 Port: WSHARB_S_ADDR, WSHARB_S_DATAOUT  out  TAM each  to shared slave bus.
REQ-012 Port: WSHARB_S_DATAIN  in  TAM; WSHARB_S_ACK/_ERR/_RTY  in  1 each  from slave bus.
REQ-013 Port: WSHARB_GNT  out  2  one-hot registered grant (bit0 = M0, bit1 = M1); 2'b00 when idle.

Function
REQ-014 FSM states SHALL be IDLE, GRANT0, GRANT1, held in registers.
REQ-015 IDLE -> GRANTx on the next edge when Mx_CYC=1; at most one grant active at any time.
REQ-016 Both CYC=1 in IDLE: grant the master not granted last (round-robin pointer LAST, 1 bit).
REQ-017 LAST SHALL update to x on each IDLE -> GRANTx transition.
REQ-018 GRANTx -> IDLE when Mx_CYC=0 and Mx_LOCK=0; every tenure ends with one IDLE cycle.
REQ-019 While Mx_LOCK=1 in GRANTx, the grant SHALL be held even if Mx_CYC drops.
REQ-020 In GRANTx, S_CYC/S_STB/S_WE/S_LOCK/S_ADDR/S_DATAOUT SHALL equal Mx's signals combinationally (zero added latency).
REQ-021 In IDLE, all WSHARB_S_* outputs SHALL be 0.
REQ-022 S_DATAIN SHALL be routed to both M0_DATAIN and M1_DATAIN unconditionally.
REQ-023 S_ACK/S_ERR/S_RTY SHALL reach only the granted master; the other master sees 0 on ACK/ERR/RTY.
REQ-024 Watchdog WDT (4-bit): increments each GRANTx cycle with Mx_STB=1 and S_ACK=S_ERR=S_RTY=0; clears on any termination, on STB=0, or outside GRANTx.
REQ-025 When WDT==TIMEOUT, Mx_ERR SHALL be driven 1 for that cycle (ORed with S_ERR) and WDT SHALL clear on the next edge.
REQ-026 Simultaneous S_ACK and S_ERR: both forwarded unmodified; the arbiter does not resolve slave protocol violations.
REQ-027 Request by the non-granted master during a tenure SHALL be held off (no termination signals) until served after the IDLE cycle.

Reset
REQ-028 WSHARB_RSTIN=1 SHALL immediately force state IDLE, LAST=1, WDT=0, WSHARB_GNT=2'b00, all WSHARB_S_* outputs 0, all M*_ACK/_ERR/_RTY 0.
REQ-029 Reset asserted mid-tenure SHALL abort the tenure with no termination to the master; first grant after release follows REQ-016 with LAST=1 (M0 wins a tie).

Verification
REQ-030 Reset release, M0_CYC=M1_CYC=1 same cycle -> GNT=01 next edge; M0 completes, drops CYC -> IDLE 1 cycle -> GNT=10.
REQ-031 M0 granted, ADDR=16'h00A5, WE=0, slave ACK after 2 cycles with S_DATAIN=16'h1234 -> M0_ACK=1, M0_DATAIN=16'h1234; M1_ACK=0.
REQ-032 M0 granted with LOCK=1, drops CYC for 3 cycles while M1_CYC=1 -> GNT stays 01; M0 LOCK=0 -> IDLE -> GNT=10.
REQ-033 M1 granted, STB=1, slave silent, TIMEOUT=15 -> M1_ERR=1 exactly in 16th STB cycle (WDT==15), single-cycle pulse.
REQ-034 RSTIN asserted asynchronously mid-read (between edges) -> GNT=00, S_CYC=0 before next clock edge; no ACK to master.
